// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply / divide unit for a MIPS-style HI/LO datapath.
//   Multiply uses a one-bit-per-cycle shift-add loop. Divide uses a
//   one-bit-per-cycle restoring loop. Both work on operand magnitudes, and
//   the sign is corrected on the edge that writes the result.
//
//   Optional feature macro: MULT_DIV_UNIT_DIV_EN
//     defined   : DIV/DIVU are computed (N iterations, divide-by-zero flag).
//     undefined : a DIV/DIVU start goes straight to DONE, and HI/LO keep
//                 their previous values.
//
// Ports
//   clk           : clock; all state changes on its rising edge
//   reset         : synchronous, active-high reset
//   start_i       : begin an operation (accepted in IDLE or DONE only)
//   op_i[1:0]     : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   Rs_Data_i     : multiplicand / dividend
//   Rt_Data_i     : multiplier / divisor
//   hi_o, lo_o    : result registers (upper product or remainder /
//                   lower product or quotient)
//   busy_o        : high while iterating (state RUN)
//   done_o        : one-cycle pulse when hi_o/lo_o carry a new result
//   div_by_zero_o : divisor was zero; valid only with done_o
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] Rs_Data_i,
  input  logic [N-1:0] Rt_Data_i,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         div_by_zero_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
    return ~v + {{(N-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
    return ~v + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  // The magnitude of the most-negative value is 2^(N-1). This still fits in
  // N unsigned bits.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic is_signed);
    return (is_signed && v[N-1]) ? neg_n(v) : v;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           sa_q, sa_d;         // raw sign bit of Rs
  logic           sb_q, sb_d;         // raw sign bit of Rt
  logic [N-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [N-1:0]   acc_hi_q, acc_hi_d; // partial product high / running remainder
  logic [N-1:0]   acc_lo_q, acc_lo_d; // multiplier bits / dividend-to-quotient
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     mul_sum_s;
  logic [N-1:0]   step_hi_s, step_lo_s;
  logic [2*N-1:0] prod_s;
  logic           neg_res_s;
  logic [N-1:0]   fin_hi_s, fin_lo_s;
  logic           fin_dbz_s;
`ifdef MULT_DIV_UNIT_DIV_EN
  logic [N+1:0]   div_diff_s;
  logic           neg_rem_s;
`endif

  // One iteration of the shift-add multiplier or the restoring divider.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    step_hi_s = mul_sum_s[N:1];
    step_lo_s = {mul_sum_s[0], acc_lo_q[N-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
    // Shift the next dividend bit into the remainder and try to subtract.
    // Bit N+1 of the difference is the borrow.
    div_diff_s = {1'b0, acc_hi_q, acc_lo_q[N-1]} - {2'b00, opnd_q};
    if (op_q[1]) begin
      if (div_diff_s[N+1]) begin
        step_hi_s = {acc_hi_q[N-2:0], acc_lo_q[N-1]};
        step_lo_s = {acc_lo_q[N-2:0], 1'b0};
      end else begin
        step_hi_s = div_diff_s[N-1:0];
        step_lo_s = {acc_lo_q[N-2:0], 1'b1};
      end
    end else begin
      step_hi_s = mul_sum_s[N:1];
      step_lo_s = {mul_sum_s[0], acc_lo_q[N-1:1]};
    end
`endif
  end

  // Sign correction and special cases, applied to the last iteration's values.
  always_comb begin
    neg_res_s = op_q[0] & (sa_q ^ sb_q);
    prod_s    = {step_hi_s, step_lo_s};
    fin_hi_s  = hi_q;
    fin_lo_s  = lo_q;
    fin_dbz_s = 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
    neg_rem_s = op_q[0] & sa_q;
`endif
    if (!op_q[1]) begin
      if (neg_res_s) begin
        prod_s = neg_2n({step_hi_s, step_lo_s});
      end else begin
        prod_s = {step_hi_s, step_lo_s};
      end
      fin_hi_s = prod_s[2*N-1:N];
      fin_lo_s = prod_s[N-1:0];
    end else begin
`ifdef MULT_DIV_UNIT_DIV_EN
      // With a zero divisor every trial subtraction succeeds. The remainder
      // then ends as the dividend magnitude, so the sign-corrected remainder
      // is the raw dividend.
      fin_hi_s = neg_rem_s ? neg_n(step_hi_s) : step_hi_s;
      if (opnd_q == {N{1'b0}}) begin
        fin_lo_s  = {N{1'b1}};
        fin_dbz_s = 1'b1;
      end else begin
        fin_lo_s  = neg_res_s ? neg_n(step_lo_s) : step_lo_s;
        fin_dbz_s = 1'b0;
      end
`else
      fin_hi_s  = hi_q;
      fin_lo_s  = lo_q;
      fin_dbz_s = 1'b0;
`endif
    end
  end

  // FSM next state, operand capture, and result update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          op_d     = op_i;
          sa_d     = Rs_Data_i[N-1];
          sb_d     = Rt_Data_i[N-1];
          acc_hi_d = {N{1'b0}};
          cnt_d    = {CW{1'b0}};
          if (op_i[1]) begin
            opnd_d   = mag(Rt_Data_i, op_i[0]);
            acc_lo_d = mag(Rs_Data_i, op_i[0]);
          end else begin
            opnd_d   = mag(Rs_Data_i, op_i[0]);
            acc_lo_d = mag(Rt_Data_i, op_i[0]);
          end
`ifdef MULT_DIV_UNIT_DIV_EN
          state_d = RUN;
`else
          if (op_i[1]) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          hi_d    = fin_hi_s;
          lo_d    = fin_lo_s;
          done_d  = 1'b1;
          dbz_d   = fin_dbz_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= {N{1'b0}};
      acc_hi_q <= {N{1'b0}};
      acc_lo_q <= {N{1'b0}};
      cnt_q    <= {CW{1'b0}};
      hi_q     <= {N{1'b0}};
      lo_q     <= {N{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule
